// File: rtl/triangle_dispatcher_pkg.sv
// Shared types for the triangle dispatcher: fixed-point vectors, the staged
// triangle bundle and the dispatcher state encoding.
package triangle_dispatcher_pkg;

  typedef logic signed [31:0] FixedPoint_t;

  typedef struct packed {
    FixedPoint_t x;
    FixedPoint_t y;
    FixedPoint_t z;
    FixedPoint_t w;
  } Vector4_t;

  typedef struct packed {
    Vector4_t v1;
    Vector4_t v2;
    Vector4_t v3;
    Vector4_t c1;
    Vector4_t c2;
    Vector4_t c3;
  } triangle_t;

  localparam logic [1:0] ENC_IDLE      = 2'b00;
  localparam logic [1:0] ENC_START     = 2'b01;
  localparam logic [1:0] ENC_WAIT_ACK  = 2'b10;
  localparam logic [1:0] ENC_WAIT_DONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = ENC_IDLE,
    START     = ENC_START,
    WAIT_ACK  = ENC_WAIT_ACK,
    WAIT_DONE = ENC_WAIT_DONE
  } state_t;

endpackage

// File: rtl/triangle_dispatcher_if.sv
// Requester / rasterizer bundle of the triangle dispatcher. The slave modport
// is the dispatcher's view, the master modport the surrounding system's view.
interface triangle_dispatcher_if #(parameter int COUNT_W = 16);
  import triangle_dispatcher_pkg::*;

  logic [1:0]         i_req_valid;
  logic [1:0]         o_req_ready;
  Vector4_t           i_req0_v1, i_req0_v2, i_req0_v3;
  Vector4_t           i_req0_c1, i_req0_c2, i_req0_c3;
  Vector4_t           i_req1_v1, i_req1_v2, i_req1_v3;
  Vector4_t           i_req1_c1, i_req1_c2, i_req1_c3;
  logic               i_pause;
  logic               o_rast_start;
  Vector4_t           o_rast_v1, o_rast_v2, o_rast_v3;
  Vector4_t           o_rast_c1, o_rast_c2, o_rast_c3;
  logic               i_rast_ready;
  logic               o_active;
  logic               o_active_src;
  logic [COUNT_W-1:0] o_tri_count;
  logic               o_timeout;

  modport slave (
    input  i_req_valid,
    input  i_req0_v1, i_req0_v2, i_req0_v3, i_req0_c1, i_req0_c2, i_req0_c3,
    input  i_req1_v1, i_req1_v2, i_req1_v3, i_req1_c1, i_req1_c2, i_req1_c3,
    input  i_pause, i_rast_ready,
    output o_req_ready, o_rast_start,
    output o_rast_v1, o_rast_v2, o_rast_v3, o_rast_c1, o_rast_c2, o_rast_c3,
    output o_active, o_active_src, o_tri_count, o_timeout
  );

  modport master (
    output i_req_valid,
    output i_req0_v1, i_req0_v2, i_req0_v3, i_req0_c1, i_req0_c2, i_req0_c3,
    output i_req1_v1, i_req1_v2, i_req1_v3, i_req1_c1, i_req1_c2, i_req1_c3,
    output i_pause, i_rast_ready,
    input  o_req_ready, o_rast_start,
    input  o_rast_v1, o_rast_v2, o_rast_v3, o_rast_c1, o_rast_c2, o_rast_c3,
    input  o_active, o_active_src, o_tri_count, o_timeout
  );

endinterface

// File: rtl/triangle_dispatcher_arbiter.sv
// Two-way round-robin arbiter: the priority holder wins when valid, and
// priority passes to the loser each time a grant is consumed.
module round_robin_arbiter2 (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic prio_q, prio_d;

  always_comb begin
    o_grant = 2'b00;
    if (i_valid[prio_q])
      o_grant[prio_q] = 1'b1;
    else if (i_valid[~prio_q])
      o_grant[~prio_q] = 1'b1;

    prio_d = prio_q;
    if (i_advance)
      prio_d = ~o_grant[1];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      prio_q <= 1'b0;
    else
      prio_q <= prio_d;
  end

endmodule

// File: rtl/triangle_dispatcher.sv
// Accepts triangles from two requesters in round-robin order and hands them,
// one at a time, to a rasterizer using a start pulse / ready-level handshake.
module triangle_dispatcher
  import triangle_dispatcher_pkg::*;
#(
  parameter int ACK_TIMEOUT = 4,
  parameter int COUNT_W     = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  triangle_dispatcher_if.slave  bus
);

  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic               src_q, src_d;
  triangle_t          stg_q, stg_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [COUNT_W-1:0] tri_count_q, tri_count_d;

  logic [1:0] grant;
  logic [1:0] req_ready;
  logic       accept;
  logic       timeout_fire;
  triangle_t  req0_tri, req1_tri;

  assign req0_tri = {bus.i_req0_v1, bus.i_req0_v2, bus.i_req0_v3,
                     bus.i_req0_c1, bus.i_req0_c2, bus.i_req0_c3};
  assign req1_tri = {bus.i_req1_v1, bus.i_req1_v2, bus.i_req1_v3,
                     bus.i_req1_c1, bus.i_req1_c2, bus.i_req1_c3};

  round_robin_arbiter2 u_arb (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_valid   (bus.i_req_valid),
    .i_advance (accept),
    .o_grant   (grant)
  );

  // Ready is gated by reset too, so nothing is accepted while reset is held.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == IDLE && !bus.i_pause && bus.i_rast_ready && !i_reset)
      req_ready = grant & bus.i_req_valid;
  end

  assign accept       = |req_ready;
  assign timeout_fire = (state_q == WAIT_ACK) && bus.i_rast_ready && (to_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    stg_d       = stg_q;
    to_cnt_d    = to_cnt_q;
    tri_count_d = tri_count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          src_d   = grant[1];
          stg_d   = grant[1] ? req1_tri : req0_tri;
        end
      end
      START: begin
        state_d  = WAIT_ACK;
        to_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (!bus.i_rast_ready) begin
          state_d = WAIT_DONE;
        end else if (timeout_fire) begin
          // A rasterizer that never drops ready is treated as having finished.
          state_d     = IDLE;
          tri_count_d = tri_count_q + COUNT_W'(1);
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.i_rast_ready) begin
          state_d     = IDLE;
          tri_count_d = tri_count_q + COUNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      src_q       <= 1'b0;
      stg_q       <= '0;
      to_cnt_q    <= '0;
      tri_count_q <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      stg_q       <= stg_d;
      to_cnt_q    <= to_cnt_d;
      tri_count_q <= tri_count_d;
    end
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_rast_start = (state_q == START);
  assign bus.o_active     = (state_q != IDLE);
  assign bus.o_active_src = src_q;
  assign bus.o_tri_count  = tri_count_q;
  assign bus.o_timeout    = timeout_fire;
  assign bus.o_rast_v1    = stg_q.v1;
  assign bus.o_rast_v2    = stg_q.v2;
  assign bus.o_rast_v3    = stg_q.v3;
  assign bus.o_rast_c1    = stg_q.c1;
  assign bus.o_rast_c2    = stg_q.c2;
  assign bus.o_rast_c3    = stg_q.c3;

endmodule

// File: tb/tb_triangle_dispatcher.sv
// Bench for triangle_dispatcher: directed scenarios then random traffic, all
// checked against a transaction-timing model of the dispatcher.
module tb_triangle_dispatcher;
  import triangle_dispatcher_pkg::*;

  localparam int T  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  triangle_dispatcher_if #(.COUNT_W(CW)) bus();

  triangle_dispatcher #(.ACK_TIMEOUT(T), .COUNT_W(CW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int ntests = 0;
  int nfail  = 0;

  // Reference model: one in-flight triangle described by its event times.
  int        cyc = 0;
  bit        busy = 0;
  int        s_cyc, a_pl, b_pl, c_cyc;
  bit        to_case;
  bit        prio = 0;
  int        count = 0;
  bit        src_m = 0;
  triangle_t stg_m = '0;
  triangle_t pay [2];
  int        order [$];
  int        seq [5] = '{1, 2, 3, 0, 1};

  task automatic chk(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_payload();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 24; k++)
        pay[r][k*32 +: 32] = $urandom;
  endtask

  task automatic drive_payload();
    bus.i_req0_v1 = pay[0].v1; bus.i_req0_v2 = pay[0].v2; bus.i_req0_v3 = pay[0].v3;
    bus.i_req0_c1 = pay[0].c1; bus.i_req0_c2 = pay[0].c2; bus.i_req0_c3 = pay[0].c3;
    bus.i_req1_v1 = pay[1].v1; bus.i_req1_v2 = pay[1].v2; bus.i_req1_v3 = pay[1].v3;
    bus.i_req1_c1 = pay[1].c1; bus.i_req1_c2 = pay[1].c2; bus.i_req1_c3 = pay[1].c3;
  endtask

  // One clock cycle. a/b describe how the rasterizer answers if a triangle
  // is accepted this cycle: ready stays high a cycles after START, then is
  // low for b cycles (a >= T means it never drops).
  task automatic cycle(input logic [1:0] valid, input bit pause, input bit idle_ready,
                       input int a, input int b);
    logic       rdy;
    logic [1:0] exp_rr;
    bit         w;
    triangle_t  rast;
    if (busy)
      rdy = (cyc <= s_cyc + a_pl) || (!to_case && cyc > s_cyc + a_pl + b_pl);
    else
      rdy = idle_ready;
    bus.i_req_valid  = valid;
    bus.i_pause      = pause;
    bus.i_rast_ready = rdy;
    drive_payload();
    #1;
    exp_rr = 2'b00;
    w = 1'b0;
    if (!busy && !pause && rdy && valid != 2'b00) begin
      w = valid[prio] ? prio : !prio;
      exp_rr[w] = 1'b1;
    end
    rast = {bus.o_rast_v1, bus.o_rast_v2, bus.o_rast_v3,
            bus.o_rast_c1, bus.o_rast_c2, bus.o_rast_c3};
    chk("req_ready", bus.o_req_ready, exp_rr);
    chk("rast_start", bus.o_rast_start, busy && cyc == s_cyc);
    chk("active", bus.o_active, busy);
    chk("timeout", bus.o_timeout, busy && to_case && cyc == s_cyc + T);
    chk("tri_count", bus.o_tri_count, count % (1 << CW));
    chk("active_src", bus.o_active_src, src_m);
    chk("rast_tri", rast, stg_m);
    if (busy && cyc == c_cyc) begin
      count++;
      busy = 0;
    end else if (exp_rr != 2'b00) begin
      src_m   = w;
      prio    = !w;
      stg_m   = pay[w];
      order.push_back(int'(w));
      s_cyc   = cyc + 1;
      a_pl    = a;
      b_pl    = b;
      to_case = (a >= T);
      c_cyc   = to_case ? s_cyc + T : s_cyc + a + b + 1;
      busy    = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asserts reset mid-cycle and checks outputs before the next clock edge.
  task automatic pulse_reset();
    triangle_t rast;
    bus.i_req_valid  = 2'b11;
    bus.i_pause      = 1'b0;
    bus.i_rast_ready = 1'b1;
    rst = 1'b1;
    #1;
    busy = 0; count = 0; prio = 0; src_m = 0; stg_m = '0;
    rast = {bus.o_rast_v1, bus.o_rast_v2, bus.o_rast_v3,
            bus.o_rast_c1, bus.o_rast_c2, bus.o_rast_c3};
    chk("rst_req_ready", bus.o_req_ready, 2'b00);
    chk("rst_start", bus.o_rast_start, 1'b0);
    chk("rst_active", bus.o_active, 1'b0);
    chk("rst_src", bus.o_active_src, 1'b0);
    chk("rst_timeout", bus.o_timeout, 1'b0);
    chk("rst_count", bus.o_tri_count, 0);
    chk("rst_tri", rast, 768'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_ready", bus.o_req_ready, 2'b00);
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    rand_payload();
    drive_payload();
    bus.i_req_valid  = 2'b00;
    bus.i_pause      = 1'b0;
    bus.i_rast_ready = 1'b1;
    @(posedge clk);
    #1;
    pulse_reset();

    // Single request from requester 0, rasterizer busy for 5 cycles.
    rand_payload();
    pay[0].v1 = {32'sd1, 32'sd2, 32'sd3, 32'sd1};
    order.delete();
    cycle(2'b01, 0, 1, 0, 5);
    cycle(2'b00, 0, 1, 0, 1);
    chk("single_v1", bus.o_rast_v1, {32'sd1, 32'sd2, 32'sd3, 32'sd1});
    repeat (8) cycle(2'b00, 0, 1, 0, 1);
    chk("single_order", order[0], 0);
    chk("single_count", bus.o_tri_count, 1);

    // Both requesters valid continuously: strict alternation from req0.
    pulse_reset();
    order.delete();
    for (int i = 0; i < 16; i++) begin
      rand_payload();
      cycle(2'b11, 0, 1, 0, 1);
    end
    chk("alt_n", order.size(), 4);
    for (int i = 0; i < 4; i++) chk("alt_order", order[i], i % 2);
    chk("alt_count", bus.o_tri_count, 4 % (1 << CW));

    // Rasterizer never drops ready: timeout path.
    pulse_reset();
    cycle(2'b01, 0, 1, T + 2, 1);
    repeat (7) cycle(2'b00, 0, 1, 0, 1);
    chk("to_count", bus.o_tri_count, 1);

    // Pause during WAIT_DONE with req1 waiting.
    pulse_reset();
    order.delete();
    cycle(2'b01, 0, 1, 0, 4);
    repeat (3) cycle(2'b00, 0, 1, 0, 1);
    repeat (8) cycle(2'b10, 1, 1, 0, 1);
    chk("pause_count", bus.o_tri_count, 1);
    chk("pause_n", order.size(), 1);
    cycle(2'b10, 0, 1, 0, 1);
    chk("pause_release", order[order.size()-1], 1);
    repeat (4) cycle(2'b00, 0, 1, 0, 1);

    // Reset during WAIT_DONE abandons the triangle; req0 wins next.
    pulse_reset();
    order.delete();
    cycle(2'b10, 0, 1, 0, 4);
    repeat (3) cycle(2'b00, 0, 1, 0, 1);
    pulse_reset();
    cycle(2'b11, 0, 1, 0, 1);
    chk("rst_regrant", order[order.size()-1], 0);
    repeat (3) cycle(2'b00, 0, 1, 0, 1);

    // Counter wrap with COUNT_W=2.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      repeat (4) cycle(2'b01, 0, 1, 0, 1);
      chk("wrap_seq", bus.o_tri_count, seq[k]);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      rand_payload();
      if ($urandom_range(0, 299) == 0)
        pulse_reset();
      else
        cycle(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 5) != 0), $urandom_range(0, T + 1),
              $urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/triangle_dispatcher.md
TRIANGLE_DISPATCHER -- requirements
Module: triangle_dispatcher

Interface
REQ-001 Parameter ACK_TIMEOUT, default 4: maximum cycles to wait for i_rast_ready to fall after o_start.
REQ-002 Parameter COUNT_W, default 16: width of completed-triangle counter.
REQ-003 Port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port i_reset  input  1  asynchronous, active-high reset.
REQ-005 Ports i_req_valid[1:0]  input  2  requester N presents a triangle.
REQ-006 Ports o_req_ready[1:0]  output  2  requester N's triangle is accepted this cycle.
REQ-007 Ports i_req0_v1/v2/v3, i_req0_c1/c2/c3, i_req1_v1/v2/v3, i_req1_c1/c2/c3  input  Vector4_t (128) each  per-requester vertex positions and colours.
REQ-008 Port i_pause  input  1  blocks acceptance of new triangles.
REQ-009 Port o_rast_start  output  1  one-cycle start pulse to the rasterizer.
REQ-010 Ports o_rast_v1/v2/v3, o_rast_c1/c2/c3  output  Vector4_t each  staged triangle driven to the rasterizer.
REQ-011 Port i_rast_ready  input  1  rasterizer ready level.
REQ-012 Port o_active  output  1  a triangle is in flight (START, WAIT_ACK or WAIT_DONE).
REQ-013 Port o_active_src  output  1  requester index of the in-flight triangle, for routing pixel writes.
REQ-014 Port o_tri_count  output  COUNT_W  completed triangles, wrap-around.
REQ-015 Port o_timeout  output  1  one-cycle pulse when the ACK timeout fires.

Function
REQ-016 States SHALL be IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-017 o_req_ready[n] SHALL be combinational: state==IDLE && !i_pause && i_rast_ready && grant[n] && i_req_valid[n].
REQ-018 Grant SHALL be round-robin: the requester with priority wins if it is valid, otherwise the other one wins; priority moves to the non-winner after each acceptance.
REQ-019 After reset, requester 0 SHALL hold priority.
REQ-020 On acceptance, the payload of the winning requester and its index SHALL be captured into staging registers, and the state SHALL go IDLE->START.
REQ-021 START SHALL last exactly one cycle with o_rast_start=1, then go to WAIT_ACK; o_rast_v*/c* SHALL equal the staged values from START until the next acceptance.
REQ-022 WAIT_ACK: i_rast_ready==0 SHALL go to WAIT_DONE; otherwise the counter increments, and after ACK_TIMEOUT cycles without a fall the state SHALL go to IDLE, pulse o_timeout and increment o_tri_count (a degenerate triangle is treated as complete).
REQ-023 WAIT_DONE: i_rast_ready==1 SHALL go to IDLE and increment o_tri_count in the same cycle.
REQ-024 At most one triangle SHALL be in flight; no acceptance outside IDLE.
REQ-025 i_pause asserted in a non-IDLE state SHALL NOT affect the in-flight triangle; it only blocks the next acceptance.
REQ-026 With both requesters valid continuously, acceptances SHALL strictly alternate 0,1,0,1...
REQ-027 o_tri_count SHALL wrap from 2^COUNT_W-1 to 0.
REQ-028 Minimum issue interval SHALL be 4 cycles (IDLE, START, WAIT_ACK, WAIT_DONE) with a 1-cycle busy rasterizer.

Reset
REQ-029 Asserting i_reset SHALL immediately (asynchronously) force: state IDLE, o_rast_start 0, o_active 0, o_active_src 0, o_timeout 0, o_tri_count 0, staging registers 0, priority to requester 0, timeout counter 0.
REQ-030 While i_reset is high, o_req_ready SHALL be 0; reset mid-triangle SHALL abandon the triangle without counting it.

Structure
REQ-031 Vector4_t and FixedPoint_t SHALL come from the shared Vector4/FixedPoint include files, and state encodings SHALL be local parameters.
REQ-032 Arbitration SHALL be a sub-module round_robin_arbiter2 (inputs: valid[1:0], advance; output: one-hot grant; holds the priority register).

Verification
REQ-033 Single request: req0 valid with v1=(1,2,3,1), rast_ready high, busy for 5 cycles -> o_req_ready[0] high for 1 cycle, o_rast_start 1 cycle later carrying v1, o_active_src=0, o_tri_count=1 after ready returns.
REQ-034 Both valid for 4 triangles -> acceptance order 0,1,0,1; o_active_src follows; o_tri_count=4.
REQ-035 Rasterizer never drops ready (ACK_TIMEOUT=4) -> o_timeout pulses 4 cycles after START, state returns to IDLE, count increments.
REQ-036 i_pause raised during WAIT_DONE with req1 valid -> current triangle completes and counts; no o_req_ready until pause drops.
REQ-037 i_reset pulsed during WAIT_DONE -> all outputs reach their reset values before the next clock edge, count 0, next grant goes to req0.
REQ-038 Count preloaded near the limit with COUNT_W=2 and 5 triangles -> o_tri_count sequence 1,2,3,0,1.
